// File: rtl/expr_pipe_pkg.sv
// Shared types and helpers for the expression pipeline: operator codes and
// the per-channel W+1 operand extension.
package expr_pipe_pkg;

    localparam int EXT_MAX = 64;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5,
        OP_LT  = 3'd6,
        OP_ACC = 3'd7
    } op_e;

    // Extends the low w bits of value to w+1 bits (and beyond, up to EXT_MAX+1).
    function automatic logic [EXT_MAX:0] ext(input logic [EXT_MAX-1:0] value,
                                             input logic              signed_flag,
                                             input int                w);
        logic [EXT_MAX:0] r;
        logic             fill;
        fill = signed_flag & value[w-1];
        for (int i = 0; i < EXT_MAX; i++) begin
            r[i] = (i < w) ? value[i] : fill;
        end
        r[EXT_MAX] = fill;
        return r;
    endfunction

endpackage

// File: rtl/expr_lane.sv
// One combinational channel: extends both operands to W+1 bits, applies the
// selected operator and truncates back to W bits.
module expr_lane
    import expr_pipe_pkg::*;
#(
    parameter int W      = 6,
    parameter bit SIGNED = 1'b0
) (
    input  op_e          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] acc,
    output logic [W-1:0] y
);

    localparam int SW = $clog2(W);

    logic [EXT_MAX:0] xa;
    logic [EXT_MAX:0] xb;
    logic [W:0]       ea;
    logic [W:0]       eb;
    logic [W:0]       r;
    logic [SW-1:0]    sh;
    logic             unused;

    assign xa = ext({{(EXT_MAX-W){1'b0}}, a}, SIGNED, W);
    assign xb = ext({{(EXT_MAX-W){1'b0}}, b}, SIGNED, W);
    assign ea = xa[W:0];
    assign eb = xb[W:0];
    assign sh = b[SW-1:0];
    assign unused = ^{r[W], xa[EXT_MAX:W+1], xb[EXT_MAX:W+1]};

    // Unsigned operands are zero-extended, so their W+1 top bit is 0: a signed
    // compare and an arithmetic shift on the extended value serve both kinds.
    // Shifts of W or more fall out naturally as zeros or sign bits.
    always_comb begin
        r = '0;
        case (op)
            OP_ADD:  r = ea + eb;
            OP_SUB:  r = ea - eb;
            OP_AND:  r = ea & eb;
            OP_XOR:  r = ea ^ eb;
            OP_SHL:  r = ea << sh;
            OP_SHR:  r = $signed(ea) >>> sh;
            OP_LT:   r = {{W{1'b0}}, ($signed(ea) < $signed(eb))};
            OP_ACC:  r = {1'b0, acc} + {1'b0, a};
            default: r = '0;
        endcase
        y = r[W-1:0];
    end

endmodule

// File: rtl/expr_pipe.sv
// Two-stage valid/ready expression pipeline over N channels, with per-channel
// accumulators, a running parity checksum and an accepted-beat counter.
module expr_pipe
    import expr_pipe_pkg::*;
#(
    parameter int           W           = 6,
    parameter int           N           = 6,
    parameter logic [N-1:0] SIGNED_MASK = 6'b111000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    input  logic           acc_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] y,
    output logic [N-1:0]   parity,
    output logic [15:0]    beats
);

    logic           ready_q;
    logic           s1_valid;
    logic           s1_clr;
    op_e            s1_op;
    logic [N*W-1:0] s1_a;
    logic [N*W-1:0] s1_b;
    logic           s2_valid;
    logic [N*W-1:0] acc;
    logic [N*W-1:0] acc_base;
    logic [N*W-1:0] lane_y;
    logic [N-1:0]   yred;
    logic           in_fire;
    logic           out_fire;
    logic           s2_free;
    logic           s1_adv;
    logic           clr_base;

    assign s2_free   = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_free;
    assign in_ready  = ready_q && (!s1_valid || s2_free);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;

    // A clear presented with a beat travels with it so it lands in acceptance
    // order; a clear with no beat offered takes effect immediately.
    assign clr_base = (s1_adv && s1_clr) || (acc_clr && !in_valid);
    assign acc_base = clr_base ? '0 : acc;

    for (genvar g = 0; g < N; g++) begin : g_lane
        expr_lane #(
            .W      (W),
            .SIGNED (SIGNED_MASK[g])
        ) u_lane (
            .op  (s1_op),
            .a   (s1_a[g*W +: W]),
            .b   (s1_b[g*W +: W]),
            .acc (acc_base[g*W +: W]),
            .y   (lane_y[g*W +: W])
        );
        assign yred[g] = ^y[g*W +: W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            s1_valid <= 1'b0;
            s1_clr   <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_valid <= 1'b0;
            y        <= '0;
            acc      <= '0;
            parity   <= '0;
            beats    <= '0;
        end else begin
            ready_q <= 1'b1;
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_clr   <= acc_clr;
                s1_op    <= op_e'(op);
                s1_a     <= a;
                s1_b     <= b;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                s2_valid <= 1'b1;
                y        <= lane_y;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
            if (s1_adv && s1_op == OP_ACC) begin
                acc <= lane_y;
            end else if (clr_base) begin
                acc <= '0;
            end
            if (out_fire) begin
                parity <= parity ^ yred;
                beats  <= beats + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_expr_pipe.sv
// Directed and randomized checks of expr_pipe against an arithmetic reference
// model with an in-order scoreboard.
module tb_expr_pipe;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int         W    = 6;
    localparam int         N    = 6;
    localparam int         NW   = N * W;
    localparam logic [5:0] MASK = 6'b111000;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [2:0]    op        = 3'd0;
    logic [NW-1:0] a         = '0;
    logic [NW-1:0] b         = '0;
    logic          acc_clr   = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [NW-1:0] y;
    logic [N-1:0]  parity;
    logic [15:0]   beats;

    int            tests = 0;
    int            fails = 0;
    logic [NW-1:0] exp_q[$];
    logic [NW-1:0] hist[$];
    logic [5:0]    macc[N];
    logic [N-1:0]  mpar;
    logic [15:0]   mbeats;
    bit            last_fi;
    logic [NW-1:0] av;
    logic [NW-1:0] bv;

    expr_pipe #(.W(W), .N(N), .SIGNED_MASK(MASK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .parity    (parity),
        .beats     (beats)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] ch(input logic [NW-1:0] v, input int i);
        return v[i*W +: W];
    endfunction

    // Reference: operands as plain integers, truncated to 6 bits at the end.
    function automatic logic [5:0] ref_lane(input int opc, input logic [5:0] ra,
                                            input logic [5:0] rb, input bit sgn);
        int va, vb, sh, res;
        va = int'(ra);
        vb = int'(rb);
        if (sgn && ra[5]) va = va - 64;
        if (sgn && rb[5]) vb = vb - 64;
        sh = int'(rb[2:0]);
        case (opc)
            0: res = va + vb;
            1: res = va - vb;
            2: res = va & vb;
            3: res = va ^ vb;
            4: res = (sh >= W) ? 0 : (va << sh);
            5: begin
                if (sh >= W) res = (va < 0) ? -1 : 0;
                else if (sgn) res = va >>> sh;
                else res = va >> sh;
            end
            6: res = (va < vb) ? 1 : 0;
            default: res = 0;
        endcase
        return res[5:0];
    endfunction

    task automatic model_accept();
        logic [NW-1:0] e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (op == 3'd7) begin
                macc[i] = (acc_clr ? 6'd0 : macc[i]) + ch(a, i);
                e[i*W +: W] = macc[i];
            end else begin
                if (acc_clr) macc[i] = 6'd0;
                e[i*W +: W] = ref_lane(int'(op), ch(a, i), ch(b, i), MASK[i]);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < N; i++) macc[i] = 6'd0;
        mpar   = '0;
        mbeats = '0;
    endtask

    task automatic step();
        logic          fi, fo;
        logic [NW-1:0] yo, e;
        #1;
        fi = in_valid && in_ready;
        fo = out_valid && out_ready;
        yo = y;
        if (fo) begin
            chk("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("y_order", 64'(yo), 64'(e));
                for (int i = 0; i < N; i++) mpar[i] = mpar[i] ^ (^e[i*W +: W]);
                mbeats = mbeats + 16'd1;
                hist.push_back(yo);
            end
        end
        if (fi) model_accept();
        @(posedge clk);
        #1;
        last_fi = fi;
        if (fo) begin
            chk("parity", 64'(parity), 64'(mpar));
            chk("beats", 64'(beats), 64'(mbeats));
        end
    endtask

    task automatic send(input logic [2:0] o, input logic [NW-1:0] va,
                        input logic [NW-1:0] vb, input logic clr);
        op       = o;
        a        = va;
        b        = vb;
        acc_clr  = clr;
        in_valid = 1'b1;
        last_fi  = 1'b0;
        for (int k = 0; k < 20 && !last_fi; k++) step();
        chk("send_accept", 64'(last_fi), 64'(1));
        in_valid = 1'b0;
        acc_clr  = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic randomize_beat();
        op = 3'($urandom_range(0, 7));
        a  = NW'({$urandom(), $urandom()});
        b  = NW'({$urandom(), $urandom()});
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", 64'(y), 64'(0));
        chk("rst_parity", 64'(parity), 64'(0));
        chk("rst_beats", 64'(beats), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(in_ready), 64'(1));

        // ADD wrap on both an unsigned and a signed channel, with latency
        av = '0; bv = '0;
        av[5:0] = 6'd63;  bv[5:0] = 6'd1;
        av[35:30] = 6'b100000; bv[35:30] = 6'b111111;
        send(3'd0, av, bv, 1'b0);
        chk("lat_cycle1", 64'(out_valid), 64'(0));
        step();
        chk("lat_cycle2", 64'(out_valid), 64'(1));
        chk("add_ch0", 64'(ch(y, 0)), 64'(6'd0));
        chk("add_ch5", 64'(ch(y, 5)), 64'(6'b011111));
        drain();

        send(3'd5, {N{6'b100000}}, {N{6'd3}}, 1'b0);
        drain();
        chk("shr3_ch0", 64'(ch(hist[hist.size()-1], 0)), 64'(6'b000100));
        chk("shr3_ch5", 64'(ch(hist[hist.size()-1], 5)), 64'(6'b111100));
        send(3'd5, {N{6'b100000}}, {N{6'd7}}, 1'b0);
        drain();
        chk("shr7_ch0", 64'(ch(hist[hist.size()-1], 0)), 64'(6'd0));
        chk("shr7_ch5", 64'(ch(hist[hist.size()-1], 5)), 64'(6'b111111));

        send(3'd6, {N{6'b111111}}, {N{6'd1}}, 1'b0);
        drain();
        chk("lt_ch0", 64'(ch(hist[hist.size()-1], 0)), 64'(6'd0));
        chk("lt_ch5", 64'(ch(hist[hist.size()-1], 5)), 64'(6'd1));

        hist.delete();
        repeat (3) send(3'd7, {N{6'd5}}, '0, 1'b0);
        send(3'd7, {N{6'd2}}, '0, 1'b1);
        drain();
        chk("acc_count", 64'(hist.size()), 64'(4));
        chk("acc_0", 64'(ch(hist[0], 0)), 64'(6'd5));
        chk("acc_1", 64'(ch(hist[1], 0)), 64'(6'd10));
        chk("acc_2", 64'(ch(hist[2], 0)), 64'(6'd15));
        chk("acc_3", 64'(ch(hist[3], 0)), 64'(6'd2));

        // Clear with no beat offered, then accumulate from zero
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        for (int i = 0; i < N; i++) macc[i] = 6'd0;
        hist.delete();
        send(3'd7, {N{6'd1}}, '0, 1'b0);
        drain();
        chk("idle_clr", 64'(ch(hist[0], 3)), 64'(6'd1));

        repeat (300) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            acc_clr   = in_valid && ($urandom_range(0, 9) == 0);
            randomize_beat();
            step();
        end
        in_valid = 1'b0;
        acc_clr = 1'b0;
        out_ready = 1'b1;
        drain();

        // Stall: continuous input, consumer blocked
        out_ready = 1'b0;
        in_valid  = 1'b1;
        randomize_beat();
        repeat (4) begin
            step();
            if (last_fi) randomize_beat();
            if (out_valid && exp_q.size() > 0) chk("stall_y", 64'(y), 64'(exp_q[0]));
        end
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        chk("stall_out_valid", 64'(out_valid), 64'(1));
        chk("stall_inflight", 64'(exp_q.size()), 64'(2));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("stall_beats", 64'(beats), 64'(mbeats));

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        randomize_beat();
        send(op, a, b, 1'b0);
        randomize_beat();
        send(op, a, b, 1'b0);
        chk("pre_rst_inflight", 64'(exp_q.size()), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_y", 64'(y), 64'(0));
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_parity", 64'(parity), 64'(0));
        chk("arst_beats", 64'(beats), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            step();
            chk("no_stale", 64'(out_valid), 64'(0));
        end

        // Beat counter wrap
        op = 3'd0;
        a = '0;
        b = '0;
        in_valid = 1'b1;
        for (int k = 0; k < 70000 && mbeats != 16'hFFFF; k++) step();
        chk("beats_ffff", 64'(beats), 64'(16'hFFFF));
        for (int k = 0; k < 5 && mbeats != 16'h0000; k++) step();
        chk("beats_wrap", 64'(beats), 64'(16'h0000));
        in_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/expr_pipe.md
# expr_pipe

Parametrised, pipelined successor to the combinational mixed-signedness expression blocks in the regression set. It evaluates one selectable operator per beat across N operand channel pairs, where each channel is individually signed or unsigned. Results are returned through a valid/ready handshake. An accumulate mode and a running parity checksum add state that carries across beats. It sits between the stimulus generator and the result scoreboard of the expression regression harness.

## Interface
- `W`, default 6: operand and result width per channel (min 2).
- `N`, default 6: number of channels.
- `SIGNED_MASK`, default 6'b111000: bit i set means channel i operands are signed.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `op` in 3: operator select, sampled with the beat.
- `a` in N*W: channel i operand A at bits [i*W +: W].
- `b` in N*W: channel i operand B, same packing.
- `acc_clr` in 1: synchronous clear of accumulators.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: consumer accepts the result.
- `y` out N*W: per-channel results, same packing as `a`.
- `parity` out N: running XOR-reduction checksum, one bit per channel.
- `beats` out 16: count of result beats accepted, wraps.

## Operation
- Operator codes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND: a&b.
  - 3 XOR: a^b.
  - 4 SHL: a<<b[log2W-1:0].
  - 5 SHR: `>>>` on signed channels, `>>` on unsigned; shift amount from b[log2W-1:0].
  - 6 LT: (a<b) zero-extended to W.
  - 7 ACC: acc_i <= acc_i + a_i, and y_i = the new acc_i.
- Width rules:
  - Compute in W+1 bits with per-channel sign extension (signed) or zero extension (unsigned).
  - Truncate results to W bits.
  - LT uses signed comparison only if the channel is signed.
  - Shift amounts ≥ W give all zeros for SHL and unsigned SHR, and all sign bits for signed SHR.
- Accumulators:
  - N×W registers that wrap modulo 2^W.
  - Change only on accepted ACC beats.
  - When `acc_clr` and an accepted ACC beat occur in the same cycle, the clear wins first: acc_i becomes a_i.
  - `acc_clr` alone zeroes them.
- parity: on each accepted output beat, parity_i <= parity_i ^ (^y_i).
- beats: increments on each accepted output beat (out_valid && out_ready) and wraps from 0xFFFF to 0.

## Timing
- Two-stage pipeline.
  - S1 registers op, a and b.
  - S2 registers the computed y.
  - Latency is 2 cycles from an accepted input to out_valid.
- Throughput is one beat per cycle when out_ready=1.
- Stall rules:
  - in_ready = !(S1 full && S2 full && !out_ready).
  - Stages advance only when their downstream stage is free or draining.
  - No bubble insertion; 2 beats maximum in flight.
- While stalled, y and out_valid stay stable until accepted.
- ACC updates at the S1→S2 transfer, so the update order matches acceptance order.
- Reset (asynchronous, rst_n=0):
  - Clears all valids, y, accumulators, parity and beats to 0.
  - in_ready becomes 1 the cycle after rst_n deasserts.
  - Reset mid-operation drops the in-flight beats with no output.

## Structure
- Package `expr_pipe_pkg`:
  - `op_e` enum for the 8 operator codes.
  - Function `ext(value, signed_flag)` for W+1 extension.
- Sub-module `expr_lane`: one combinational channel (operator mux, extension, truncation), instantiated N times with its `SIGNED` bit from SIGNED_MASK.
- `expr_pipe` holds the pipeline registers, handshake, accumulators, parity and counter.

## Test plan
- Reset with defaults → y=0, parity=0, beats=0, out_valid=0. Send ADD with ch0 a=6'd63, b=6'd1 and ch5 a=-6'sd32, b=-6'sd1 → after 2 cycles ch0=0 (wrap) and ch5=6'b011111 (wrap).
- SHR with a=6'b100000, b=3 → signed ch5=6'b111100, unsigned ch0=6'b000100. SHR with b=7 → ch5=6'b111111, ch0=0.
- LT with a=6'b111111, b=1 → ch0=0 (unsigned 63<1 false), ch5=1 (signed -1<1 true).
- Three ACC beats with a=5, then acc_clr plus ACC with a=2 → outputs 5, 10, 15, then 2; parity toggles per ^y.
- Hold out_ready=0 for 4 cycles with a continuous input stream → exactly 2 beats in flight, in_ready=0, y stable; release → in-order delivery, no loss or duplication, beats counts correctly.
- Assert rst_n low mid-stream with 2 beats in flight → all outputs zero immediately (asynchronous), no stale beat after release. Also preload beats=0xFFFF and accept one beat → beats wraps to 0.
